// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared, external combinational ALU.
// A granted request is latched in IDLE, held on the alu_* bus for one EXEC
// cycle, and its result is then held for the owning requester until consumed.
module alu_arbiter #(
    parameter int unsigned PRIO_RESET = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic [31:0] req0_opA,
    input  logic [31:0] req0_opB,
    input  logic [4:0]  req0_opcode,
    input  logic [4:0]  req0_shamt,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [31:0] req1_opA,
    input  logic [31:0] req1_opB,
    input  logic [4:0]  req1_opcode,
    input  logic [4:0]  req1_shamt,
    output logic        req1_ready,

    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,

    output logic [31:0] resp_data,
    output logic        resp_ne,
    output logic        resp_lt,
    output logic        resp_ovf,
    output logic        resp_err,

    output logic [31:0] alu_opA,
    output logic [31:0] alu_opB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_ne,
    input  logic        alu_lt,
    input  logic        alu_ovf
);

    localparam logic PRIO = (PRIO_RESET != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        owner;
    logic        last_owner;
    logic [31:0] opA_q;
    logic [31:0] opB_q;
    logic [4:0]  opcode_q;
    logic [4:0]  shamt_q;

    logic        grant_valid;
    logic        grant_idx;
    logic        opcode_legal;
    logic        owner_ready;

    // Grant selection: a lone requester wins; on contention the port that
    // did not own the last accept wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_idx   = ~last_owner;
        end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_idx   = 1'b0;
        end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_idx   = 1'b1;
        end
    end

    assign opcode_legal = (opcode_q <= 5'd5);
    assign owner_ready  = owner ? resp1_ready : resp0_ready;

    assign req0_ready  = !reset && (state == IDLE) && grant_valid && !grant_idx;
    assign req1_ready  = !reset && (state == IDLE) && grant_valid &&  grant_idx;
    assign resp0_valid = (state == RESP) && !owner;
    assign resp1_valid = (state == RESP) &&  owner;

    assign alu_opA    = opA_q;
    assign alu_opB    = opB_q;
    assign alu_opcode = opcode_q;
    assign alu_shamt  = shamt_q;

    // Transaction FSM: accept and latch, one execute cycle, hold response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= ~PRIO;
            opA_q      <= '0;
            opB_q      <= '0;
            opcode_q   <= '0;
            shamt_q    <= '0;
            resp_data  <= '0;
            resp_ne    <= 1'b0;
            resp_lt    <= 1'b0;
            resp_ovf   <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        opA_q      <= grant_idx ? req1_opA    : req0_opA;
                        opB_q      <= grant_idx ? req1_opB    : req0_opB;
                        opcode_q   <= grant_idx ? req1_opcode : req0_opcode;
                        shamt_q    <= grant_idx ? req1_shamt  : req0_shamt;
                        owner      <= grant_idx;
                        last_owner <= grant_idx;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (opcode_legal) begin
                        resp_data <= alu_result;
                        resp_ne   <= alu_ne;
                        resp_lt   <= alu_lt;
                        resp_ovf  <= alu_ovf;
                        resp_err  <= 1'b0;
                    end else begin
                        resp_data <= '0;
                        resp_ne   <= 1'b0;
                        resp_lt   <= 1'b0;
                        resp_ovf  <= 1'b0;
                        resp_err  <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
